// File: rtl/min_frame_loader.sv
// Packs a serial stream of 3-bit samples into four operand registers (x..w)
// for the minimum finder. Optional equal-operand flag: MIN_FRAME_LOADER_TIE_EN.
module min_frame_loader (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       flush,
   output logic [2:0] x,
   output logic [2:0] y,
   output logic [2:0] z,
   output logic [2:0] w,
   output logic       out_valid,
   input  logic       out_ack,
   output logic [1:0] count,
   output logic [7:0] frames,
   output logic       tie
);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [2:0] x_r;
   logic [2:0] y_r;
   logic [2:0] z_r;
   logic [2:0] w_r;
   logic [1:0] count_r;
   logic [7:0] frames_r;
   logic       accept_s;
   logic       last_s;
   logic       ack_s;

   // A dropped sample under flush never touches the operands or the count.
   assign accept_s = in_valid && (state_r == FILL) && !flush;
   assign last_s   = accept_s && (count_r == 2'd3);
   assign ack_s    = (state_r == FULL) && out_ack && !flush;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= FILL;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         FILL: begin
            if (flush) begin
               state_s = FILL;
            end else if (last_s) begin
               state_s = FULL;
            end else begin
               state_s = FILL;
            end
         end
         FULL: begin
            if (flush || out_ack) begin
               state_s = FILL;
            end else begin
               state_s = FULL;
            end
         end
         default: begin
            state_s = FILL;
         end
      endcase
   end

   // Operand capture and partial-frame count; the count wraps 3 -> 0 on the last sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r     <= 3'd0;
         y_r     <= 3'd0;
         z_r     <= 3'd0;
         w_r     <= 3'd0;
         count_r <= 2'd0;
      end else if (flush) begin
         count_r <= 2'd0;
      end else if (accept_s) begin
         case (count_r)
            2'd0:    x_r <= in_data;
            2'd1:    y_r <= in_data;
            2'd2:    z_r <= in_data;
            2'd3:    w_r <= in_data;
            default: x_r <= in_data;
         endcase
         count_r <= count_r + 2'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // Delivered-frame counter, wrapping modulo 256
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_r <= 8'd0;
      end else if (ack_s) begin
         frames_r <= frames_r + 8'd1;
      end else begin
         frames_r <= frames_r;
      end
   end

`ifdef MIN_FRAME_LOADER_TIE_EN
   // True when any of the six operand pairs match.
   function automatic logic any_equal(input logic [2:0] a, input logic [2:0] b,
                                      input logic [2:0] c, input logic [2:0] d);
      return (a == b) || (a == c) || (a == d) ||
             (b == c) || (b == d) || (c == d);
   endfunction

   logic tie_r;

   // Tie flag captured together with the completing sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tie_r <= 1'b0;
      end else if (flush) begin
         tie_r <= 1'b0;
      end else if (last_s) begin
         tie_r <= any_equal(x_r, y_r, z_r, in_data);
      end else begin
         tie_r <= tie_r;
      end
   end

   assign tie = tie_r;
`else
   assign tie = 1'b0;
`endif

   assign in_ready  = (state_r == FILL);
   assign out_valid = (state_r == FULL);
   assign x         = x_r;
   assign y         = y_r;
   assign z         = z_r;
   assign w         = w_r;
   assign count     = count_r;
   assign frames    = frames_r;

endmodule

// File: tb/tb_min_frame_loader.sv
// Scoreboard bench for min_frame_loader: a behavioural model predicts frames,
// handshake and counters; completed frames are queued and popped on out_valid.
module tb_min_frame_loader;

   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic [2:0] z;
      logic [2:0] w;
      logic       t;
   } frame_t;

`ifdef MIN_FRAME_LOADER_TIE_EN
   localparam bit TIE_EN = 1'b1;
`else
   localparam bit TIE_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       flush;
   logic [2:0] x, y, z, w;
   logic       out_valid;
   logic       out_ack;
   logic [1:0] count;
   logic [7:0] frames;
   logic       tie;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit         m_full;
   int         m_count;
   logic [2:0] m_buf [4];
   logic [7:0] m_frames;
   bit         m_tie;
   int         m_acc;
   frame_t     sb [$];
   bit         prev_ov;

   min_frame_loader dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .flush(flush), .x(x), .y(y), .z(z), .w(w),
      .out_valid(out_valid), .out_ack(out_ack), .count(count),
      .frames(frames), .tie(tie)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_full   = 1'b0;
      m_count  = 0;
      m_frames = 8'd0;
      m_tie    = 1'b0;
      prev_ov  = 1'b0;
      sb.delete();
   endtask

   task automatic model_update();
      frame_t f;
      int     eq;
      if (flush) begin
         m_full  = 1'b0;
         m_count = 0;
         m_tie   = 1'b0;
      end else if (!m_full) begin
         if (in_valid) begin
            m_buf[m_count] = in_data;
            m_acc++;
            if (m_count == 3) begin
               eq = 0;
               for (int i = 0; i < 4; i++)
                  for (int j = i + 1; j < 4; j++)
                     if (m_buf[i] == m_buf[j]) eq++;
               m_tie   = TIE_EN && (eq != 0);
               m_full  = 1'b1;
               m_count = 0;
               f = '{x: m_buf[0], y: m_buf[1], z: m_buf[2], w: m_buf[3], t: m_tie};
               sb.push_back(f);
            end else begin
               m_count++;
            end
         end
      end else if (out_ack) begin
         m_full   = 1'b0;
         m_frames = m_frames + 8'd1;
      end
   endtask

   task automatic monitor();
      frame_t e;
      check_eq("in_ready", {31'd0, in_ready}, {31'd0, !m_full});
      check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      check_eq("count", {30'd0, count}, m_count);
      check_eq("frames", {24'd0, frames}, {24'd0, m_frames});
      check_eq("tie", {31'd0, tie}, {31'd0, m_tie});
      if (out_valid && !prev_ov) begin
         check_eq("sb_pending", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("frame", {19'd0, x, y, z, w, tie}, {19'd0, e});
         end
      end
      prev_ov = out_valid;
   endtask

   // One clock: model sees the inputs at the edge, outputs checked on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      monitor();
   endtask

   task automatic send(input logic [2:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic ack_one();
      out_ack = 1'b1;
      cycle();
      out_ack = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_xyzw"}, {20'd0, x, y, z, w}, 32'd0);
      check_eq({tag, "_count"}, {30'd0, count}, 32'd0);
      check_eq({tag, "_frames"}, {24'd0, frames}, 32'd0);
      check_eq({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      check_eq({tag, "_tie"}, {31'd0, tie}, 32'd0);
   endtask

   initial begin
      int         cyc;
      logic [7:0] fsav;
      rst_n = 1'b0; in_data = 3'd0; in_valid = 1'b0; flush = 1'b0; out_ack = 1'b0;
      m_acc = 0;
      model_reset();
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic frame, then a sample offered while FULL
      send(3'd5); send(3'd3); send(3'd6); send(3'd1);
      check_eq("t1_xyzw", {20'd0, x, y, z, w}, {20'd0, 3'd5, 3'd3, 3'd6, 3'd1});
      check_eq("t1_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1; in_data = 3'd7;
      cycle(); cycle();
      in_valid = 1'b0;
      check_eq("t1_held", {20'd0, x, y, z, w}, {20'd0, 3'd5, 3'd3, 3'd6, 3'd1});
      ack_one();

      // continuous ack, 12 samples streamed back-to-back
      fsav = m_frames;
      cyc = 0;
      out_ack = 1'b1; in_valid = 1'b1;
      while (frames != fsav + 8'd3 && cyc < 40) begin
         in_data = 3'((m_acc * 3 + 1) % 8);
         cycle();
         cyc++;
      end
      out_ack = 1'b0; in_valid = 1'b0;
      check_eq("t2_cycles", cyc, 32'd15);
      check_eq("t2_frames", {24'd0, frames}, {24'd0, fsav + 8'd3});

      // tie detection
      send(3'd2); send(3'd2); send(3'd4); send(3'd7);
      check_eq("t3_tie1", {31'd0, tie}, {31'd0, TIE_EN});
      ack_one();
      send(3'd0); send(3'd1); send(3'd2); send(3'd3);
      check_eq("t3_tie0", {31'd0, tie}, 32'd0);
      ack_one();

      // flush of a partial frame
      send(3'd4); send(3'd4);
      check_eq("t4_count2", {30'd0, count}, 32'd2);
      flush = 1'b1; cycle(); flush = 1'b0;
      check_eq("t4_count0", {30'd0, count}, 32'd0);
      send(3'd1); send(3'd2); send(3'd3); send(3'd0);
      check_eq("t4_xyzw", {20'd0, x, y, z, w}, {20'd0, 3'd1, 3'd2, 3'd3, 3'd0});
      ack_one();

      // flush together with ack while FULL
      send(3'd6); send(3'd6); send(3'd6); send(3'd6);
      fsav = m_frames;
      flush = 1'b1; out_ack = 1'b1; cycle(); flush = 1'b0; out_ack = 1'b0;
      check_eq("t5_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("t5_frames", {24'd0, frames}, {24'd0, fsav});

      // 256 frames from a clean reset
      @(negedge clk); rst_n = 1'b0; #1; model_reset();
      @(negedge clk); rst_n = 1'b1;
      out_ack = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 255 * 5; i++) begin
         in_data = 3'($urandom_range(0, 7));
         cycle();
      end
      check_eq("t6_frames255", {24'd0, frames}, 32'd255);
      for (int i = 0; i < 5; i++) begin
         in_data = 3'($urandom_range(0, 7));
         cycle();
      end
      check_eq("t6_frames_wrap", {24'd0, frames}, 32'd0);
      out_ack = 1'b0; in_valid = 1'b0;

      // asynchronous reset mid-frame
      send(3'd6); send(3'd5); send(3'd4);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("t7_async");
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      send(3'd3); send(3'd1); send(3'd7); send(3'd2);
      check_eq("t7_xyzw", {20'd0, x, y, z, w}, {20'd0, 3'd3, 3'd1, 3'd7, 3'd2});
      ack_one();

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
